bit_serializer: RTL

- Parallel-to-serial stage that sits directly upstream of the serial-in shift register.
- Accepts a BITS-wide word over a valid/ready handshake and emits it one bit per clock on o_bit.
- Emits a per-word direction flag alongside the bits, so the downstream register reassembles the word in its original bit positions.
- Optional idle gap between words; first and last bit of each word are flagged.

---
 rtl/bit_serializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts a BITS-wide word over valid/ready and
// emits it one bit per clock with per-word direction, first/last flags and an optional idle gap.
module bit_serializer #(
  parameter int BITS       = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [BITS-1:0] i_data,
  input  logic            i_right_nleft,
  output logic            o_bit,
  output logic            o_bit_valid,
  output logic            o_right_nleft,
  output logic            o_first,
  output logic            o_last,
  output logic            o_busy
);

  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, idx_d;
  logic [BITS-1:0] word_q, word_d;
  logic            dir_q, dir_d;
  logic            bit_q, bit_d;
  logic            valid_q, valid_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            last_bit, take, gap_done;

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
  assign o_ready  = (state_q == IDLE) || (last_bit && (GAP_CYCLES == 0));
  assign take     = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = SHIFT;
          cnt_d   = '0;
          word_d  = i_data;
          dir_d   = i_right_nleft;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
          end else if (take) begin
            // Reload on the last bit so consecutive words leave no bubble.
            cnt_d  = '0;
            word_d = i_data;
            dir_d  = i_right_nleft;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (gap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so they can be registered.
    idx_d   = dir_d ? cnt_d : (LAST - cnt_d);
    valid_d = (state_d == SHIFT);
    bit_d   = valid_d && word_d[idx_d];
    first_d = valid_d && (cnt_d == '0);
    last_d  = valid_d && (cnt_d == LAST);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      dir_q   <= 1'b0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  if (GAP_CYCLES > 0) begin : g_gap
    localparam int GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0] gap_q, gap_d;

    // Counts cycles already spent in GAP; starts at zero on entry.
    always_comb gap_d = (state_q == GAP) ? gap_q + GW'(1) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) gap_q <= '0;
      else          gap_q <= gap_d;
    end

    assign gap_done = (gap_q == GW'(GAP_CYCLES - 1));
  end else begin : g_no_gap
    assign gap_done = 1'b1;
  end

  assign o_bit         = bit_q;
  assign o_bit_valid   = valid_q;
  assign o_right_nleft = dir_q;
  assign o_first       = first_q;
  assign o_last        = last_q;
  assign o_busy        = busy_q;

endmodule
